// File: rtl/regfile_dbg_ctrl.sv
// rtl/regfile_dbg_ctrl.sv - register-file port arbiter and debug read/write/dump sequencer
`timescale 1ns/1ps

module regfile_dbg_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        halt_req,
  input  logic        halt_ack,
  input  logic        dbg_req,
  input  logic [1:0]  dbg_cmd,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_busy,
  output logic        dbg_ack,
  output logic        dbg_err,
  output logic [31:0] dbg_rdata,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [4:0]  dump_addr,
  output logic [31:0] dump_data,
  output logic        dump_last,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        rf_rs_sel,
  output logic [4:0]  rf_dbg_raddr,
  input  logic [31:0] rf_data_1
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT_WAIT,
    S_READ,
    S_WRITE,
    S_DUMP_LOAD,
    S_DUMP_SEND,
    S_RELEASE
  } state_t;

  localparam logic [1:0] CMD_READ  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_RSVD  = 2'b11;

  state_t      state_q, state_d;
  logic [1:0]  cmd_q, cmd_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  idx_q, idx_d;
  logic        halt_q, halt_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        dv_q, dv_d;
  logic [4:0]  da_q, da_d;
  logic [31:0] dd_q, dd_d;
  logic        dl_q, dl_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cmd_q   <= 2'b00;
      addr_q  <= 5'd0;
      wdata_q <= 32'd0;
      idx_q   <= 5'd0;
      halt_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      dv_q    <= 1'b0;
      da_q    <= 5'd0;
      dd_q    <= 32'd0;
      dl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      halt_q  <= halt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      dv_q    <= dv_d;
      da_q    <= da_d;
      dd_q    <= dd_d;
      dl_q    <= dl_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    idx_d        = idx_q;
    halt_d       = halt_q;
    err_d        = 1'b0;
    rdata_d      = rdata_q;
    dv_d         = dv_q;
    da_d         = da_q;
    dd_d         = dd_q;
    dl_d         = dl_q;
    // Pipeline owns the write port unless a debug write is actually committing.
    rf_we        = wb_we && (wb_addr != 5'd0);
    rf_waddr     = wb_addr;
    rf_wdata     = wb_data;
    rf_rs_sel    = 1'b0;
    rf_dbg_raddr = 5'd0;

    unique case (state_q)
      S_IDLE: begin
        if (dbg_req) begin
          cmd_d   = dbg_cmd;
          addr_d  = dbg_addr;
          wdata_d = dbg_wdata;
          if (dbg_cmd == CMD_RSVD) begin
            err_d   = 1'b1;
            state_d = S_RELEASE;
          end else begin
            halt_d  = 1'b1;
            state_d = S_HALT_WAIT;
          end
        end
      end
      S_HALT_WAIT: begin
        if (halt_ack) begin
          if (cmd_q == CMD_READ) begin
            state_d = S_READ;
          end else if (cmd_q == CMD_WRITE) begin
            state_d = S_WRITE;
          end else begin
            idx_d   = 5'd0;
            state_d = S_DUMP_LOAD;
          end
        end
      end
      S_READ: begin
        rf_rs_sel    = 1'b1;
        rf_dbg_raddr = addr_q;
        rdata_d      = rf_data_1;
        state_d      = S_RELEASE;
      end
      S_WRITE: begin
        // A stray WB write takes the port; the debug write retries next cycle.
        if (!wb_we) begin
          rf_we    = (addr_q != 5'd0);
          rf_waddr = addr_q;
          rf_wdata = wdata_q;
          err_d    = (addr_q == 5'd0);
          state_d  = S_RELEASE;
        end
      end
      S_DUMP_LOAD: begin
        rf_rs_sel    = 1'b1;
        rf_dbg_raddr = idx_q;
        dd_d         = rf_data_1;
        da_d         = idx_q;
        dl_d         = (idx_q == 5'd31);
        dv_d         = 1'b1;
        state_d      = S_DUMP_SEND;
      end
      S_DUMP_SEND: begin
        rf_rs_sel    = 1'b1;
        rf_dbg_raddr = idx_q;
        if (dv_q && dump_ready) begin
          dv_d = 1'b0;
          if (idx_q == 5'd31) begin
            state_d = S_RELEASE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = S_DUMP_LOAD;
          end
        end
      end
      S_RELEASE: begin
        halt_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ack_d = (state_d == S_RELEASE);
  end

  assign halt_req   = halt_q;
  assign dbg_busy   = (state_q != S_IDLE);
  assign dbg_ack    = ack_q;
  assign dbg_err    = err_q;
  assign dbg_rdata  = rdata_q;
  assign dump_valid = dv_q;
  assign dump_addr  = da_q;
  assign dump_data  = dd_q;
  assign dump_last  = dl_q;

endmodule

// File: tb/tb_regfile_dbg_ctrl.sv
// tb/tb_regfile_dbg_ctrl.sv - directed self-checking bench for regfile_dbg_ctrl
`timescale 1ns/1ps

module tb_regfile_dbg_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        halt_req;
  logic        halt_ack;
  logic        dbg_req;
  logic [1:0]  dbg_cmd;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_busy;
  logic        dbg_ack;
  logic        dbg_err;
  logic [31:0] dbg_rdata;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        dump_last;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_rs_sel;
  logic [4:0]  rf_dbg_raddr;
  logic [31:0] rf_data_1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [32];
  logic        mem_clr;
  int          ack_count = 0;
  int          halt_count = 0;

  always #5 clk = ~clk;

  regfile_dbg_ctrl dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .halt_req(halt_req), .halt_ack(halt_ack),
    .dbg_req(dbg_req), .dbg_cmd(dbg_cmd), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_busy(dbg_busy), .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
    .dump_data(dump_data), .dump_last(dump_last),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_rs_sel(rf_rs_sel), .rf_dbg_raddr(rf_dbg_raddr), .rf_data_1(rf_data_1)
  );

  // Register file: negedge write, combinational rs read (decode side parked on r0).
  always @(negedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
    end else if (rf_we) begin
      mem[rf_waddr] <= rf_wdata;
    end
  end
  assign rf_data_1 = rf_rs_sel ? mem[rf_dbg_raddr] : mem[0];

  always @(posedge clk) begin
    if (dbg_ack)  ack_count  <= ack_count + 1;
    if (halt_req) halt_count <= halt_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1'b1; wb_addr = a; wb_data = d;
    @(posedge clk); #1;
    wb_we = 1'b0;
  endtask

  task automatic dbg_op(input logic [1:0] cmd, input logic [4:0] a, input logic [31:0] d,
                        output int ack_at, output logic err);
    ack_at = -1; err = 1'b0;
    dbg_req = 1'b1; dbg_cmd = cmd; dbg_addr = a; dbg_wdata = d;
    @(posedge clk); #1;
    dbg_req = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (dbg_ack) begin ack_at = k; err = dbg_err; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic run_dump(input bit rnd, input int stop_after,
                          output int words, output int bad, output int ack_at);
    logic [31:0] held_d;
    logic [4:0]  held_a;
    bit          holding;
    bit          prev_hs;
    words = 0; bad = 0; ack_at = -1; holding = 0; prev_hs = 0;
    held_d = 32'd0; held_a = 5'd0;
    dbg_req = 1'b1; dbg_cmd = 2'b10; dbg_addr = 5'd0;
    dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    dbg_req = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (prev_hs && dump_valid) bad++;
      prev_hs = 0;
      if (dbg_ack) begin ack_at = k; break; end
      if (dump_valid) begin
        if (holding && (dump_data !== held_d || dump_addr !== held_a)) bad++;
        held_d = dump_data; held_a = dump_addr; holding = 1;
        if (dump_ready) begin
          chk("dump_addr", {27'd0, dump_addr}, words);
          chk("dump_data", dump_data, words * 32'h01010101);
          chk("dump_last", {31'd0, dump_last}, {31'd0, words == 31});
          words++; holding = 0; prev_hs = 1;
        end
      end
      @(posedge clk); #1;
      dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stop_after > 0 && words == stop_after) return;
    end
    dump_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ack_at;
    logic        err;
    int          words;
    int          bad;
    int          acks0;
    int          halts0;

    reset = 1'b1; mem_clr = 1'b1;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    halt_ack = 1'b1; dbg_req = 1'b0; dbg_cmd = 2'b00; dbg_addr = 5'd0; dbg_wdata = 32'd0;
    dump_ready = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("rst_ctrl", {25'd0, halt_req, dbg_busy, dbg_ack, dbg_err, dump_valid, dump_last, rf_rs_sel}, 32'd0);
    chk("rst_rdata", dbg_rdata, 32'd0);
    chk("rst_dump", {dump_addr, rf_dbg_raddr, 22'd0} | dump_data, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    mem_clr = 1'b0; reset = 1'b1;
    @(posedge clk); #1;

    // WB write to r0 must never reach the register file.
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hCAFE0000;
    @(negedge clk);
    chk("wb_r0_drop", {31'd0, rf_we}, 32'd0);
    @(posedge clk); #1;
    wb_we = 1'b0;

    wb_write(5'd5, 32'hDEADBEEF);
    dbg_op(2'b00, 5'd5, 32'd0, ack_at, err);
    chk("read_ack_at", ack_at, 32'd2);
    chk("read_err", {31'd0, err}, 32'd0);
    chk("read_data", dbg_rdata, 32'hDEADBEEF);
    chk("read_halt_released", {31'd0, halt_req}, 32'd0);
    chk("idle_rs_sel", {31'd0, rf_rs_sel}, 32'd0);

    dbg_op(2'b01, 5'd9, 32'h12345678, ack_at, err);
    chk("write_ack_at", ack_at, 32'd2);
    chk("write_err", {31'd0, err}, 32'd0);
    dbg_op(2'b00, 5'd9, 32'd0, ack_at, err);
    chk("write_readback", dbg_rdata, 32'h12345678);

    dbg_op(2'b01, 5'd0, 32'hFFFFFFFF, ack_at, err);
    chk("write_r0_ack_at", ack_at, 32'd2);
    chk("write_r0_err", {31'd0, err}, 32'd1);
    dbg_op(2'b00, 5'd0, 32'd0, ack_at, err);
    chk("read_r0", dbg_rdata, 32'd0);

    halts0 = halt_count;
    dbg_op(2'b11, 5'd2, 32'd0, ack_at, err);
    chk("rsvd_ack_at", ack_at, 32'd0);
    chk("rsvd_err", {31'd0, err}, 32'd1);
    chk("rsvd_no_halt", halt_count, halts0);
    chk("rsvd_rdata_kept", dbg_rdata, 32'd0);

    // Halt handshake: ack withheld for 10 cycles, stray requests in between.
    halt_ack = 1'b0;
    dbg_req = 1'b1; dbg_cmd = 2'b00; dbg_addr = 5'd9;
    @(posedge clk); #1;
    dbg_req = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!dbg_busy || !halt_req || rf_rs_sel || rf_we || dbg_ack) bad++;
      @(posedge clk); #1;
      if (k == 3) begin
        dbg_req = 1'b1; dbg_cmd = 2'b01; dbg_addr = 5'd7; dbg_wdata = 32'h00000055;
      end
      if (k == 4) dbg_req = 1'b0;
    end
    chk("halt_wait_quiet", bad, 32'd0);
    halt_ack = 1'b1;
    ack_at = -1;
    for (int k = 10; k < 200; k++) begin
      @(negedge clk);
      if (dbg_ack) begin ack_at = k; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("halt_ack_at", ack_at, 32'd12);
    chk("halt_read_data", dbg_rdata, 32'h12345678);
    @(posedge clk); @(posedge clk); #1;
    chk("stray_req_not_queued", {31'd0, dbg_busy}, 32'd0);
    dbg_op(2'b00, 5'd7, 32'd0, ack_at, err);
    chk("stray_write_dropped", dbg_rdata, 32'd0);

    // Collision: WB write during debug WRITE gets the port first.
    acks0 = ack_count;
    dbg_req = 1'b1; dbg_cmd = 2'b01; dbg_addr = 5'd4; dbg_wdata = 32'h0000BBBB;
    @(posedge clk); #1;
    dbg_req = 1'b0;
    @(posedge clk); #1;
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000AAAA;
    @(negedge clk);
    chk("coll_wb_port", {rf_we, 22'd0, rf_waddr, 4'd0} ^ (rf_wdata << 16), {1'b1, 22'd0, 5'd3, 4'd0} ^ 32'hAAAA0000);
    @(posedge clk); #1;
    wb_we = 1'b0;
    @(negedge clk);
    chk("coll_dbg_port_we", {31'd0, rf_we}, 32'd1);
    chk("coll_dbg_port_addr", {27'd0, rf_waddr}, 32'd4);
    chk("coll_dbg_port_data", rf_wdata, 32'h0000BBBB);
    chk("coll_no_early_ack", {31'd0, dbg_ack}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("coll_ack", {30'd0, dbg_ack, dbg_err}, 32'd2);
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    chk("coll_single_ack", ack_count - acks0, 32'd1);
    dbg_op(2'b00, 5'd3, 32'd0, ack_at, err);
    chk("coll_r3", dbg_rdata, 32'h0000AAAA);
    dbg_op(2'b00, 5'd4, 32'd0, ack_at, err);
    chk("coll_r4", dbg_rdata, 32'h0000BBBB);

    for (int i = 1; i < 32; i++) wb_write(5'(i), i * 32'h01010101);

    run_dump(1'b1, 0, words, bad, ack_at);
    chk("dump_words", words, 32'd32);
    chk("dump_stable_and_gapped", bad, 32'd0);
    chk("dump_acked", {31'd0, ack_at >= 64}, 32'd1);
    chk("dump_halt_released", {31'd0, halt_req}, 32'd0);

    // Reset in the middle of a dump, right after the word at addr 10.
    run_dump(1'b0, 11, words, bad, ack_at);
    chk("mid_words_before_reset", words, 32'd11);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ctrl", {25'd0, halt_req, dbg_busy, dbg_ack, dbg_err, dump_valid, dump_last, rf_rs_sel}, 32'd0);
    chk("mid_rst_rdata", dbg_rdata, 32'd0);
    chk("mid_rst_dump_addr", {27'd0, dump_addr}, 32'd0);
    chk("mid_rst_dump_data", dump_data, 32'd0);
    chk("mid_rst_raddr", {27'd0, rf_dbg_raddr}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_dump(1'b0, 0, words, bad, ack_at);
    chk("redump_words", words, 32'd32);
    chk("redump_clean", bad, 32'd0);
    chk("redump_ack_at", ack_at, 32'd65);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
